fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DSIZE, default 8: data width, equal to the attached FIFO's DSIZE.
REQ-002 Parameter SKID, default 2, fixed at 2: output buffer depth in words.
REQ-003 rclk  input  1  read-domain clock; all logic is on its rising edge.
REQ-004 rrst  input  1  reset, synchronous, active-high.
REQ-005 rempty  input  1  FIFO empty flag from the read-pointer/empty logic.
REQ-006 rdata  input  DSIZE  FIFO read data, valid in the same cycle whenever rempty=0.
REQ-007 rinc  output  1  FIFO read increment (pop).
REQ-008 flush  input  1  discards buffered words; FIFO contents are untouched.
REQ-009 m_valid  output  1  output word valid.
REQ-010 m_ready  input  1  downstream accept.
REQ-011 m_data  output  DSIZE  output word (head of buffer).

Function
REQ-012 rinc SHALL equal (!rempty && count<2 && !flush && !rrst), where count is the number of buffered words; rinc SHALL have no combinational dependence on m_ready.
REQ-013 On each rclk edge with rinc=1, rdata SHALL be written into the buffer tail.
REQ-014 Latency: a word popped at edge N SHALL appear on m_data with m_valid=1 from edge N onward, i.e. m_valid is asserted one cycle after the first rinc.
REQ-015 A pop SHALL occur when m_valid && m_ready; the next word, if present, SHALL be presented in the following cycle.
REQ-016 m_valid SHALL be 1 exactly when count>0; m_data and m_valid SHALL be driven from registers.
REQ-017 While m_valid=1 and m_ready=0, m_data SHALL remain stable.
REQ-018 State machine on count: EMPTY(0), ONE(1), TWO(2).
- EMPTY: on push, go to ONE; otherwise stay.
- ONE: push without pop goes to TWO; pop without push goes to EMPTY; push with pop, or neither, stays in ONE.
- TWO: pop goes to ONE (no push is possible); otherwise stay.
REQ-019 In state ONE, simultaneous push and pop SHALL sustain one word per cycle.
REQ-020 Word order SHALL be preserved exactly.
REQ-021 flush=1 SHALL force state EMPTY at the next edge, drop any push or pop in that cycle, and assert no rinc.
REQ-022 If rempty rises while words are buffered, the buffer SHALL continue to drain normally.

Reset
REQ-023 rrst=1 at an rclk edge SHALL set state EMPTY, m_valid=0, m_data=0, and the read counter (when present) to 0.
REQ-024 rinc SHALL be 0 during rrst, including when rrst is asserted mid-stream.
REQ-025 Buffered words SHALL be discarded on rrst.

Configuration
REQ-026 Macro FIFO_RD_CNT_EN: when defined, output rd_cnt [15:0] SHALL count accepted words (m_valid && m_ready), wrap modulo 2^16, and be cleared by rrst or flush.
REQ-027 When FIFO_RD_CNT_EN is undefined, the rd_cnt port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-028 Shared package fifo_pkg SHALL hold the rd_state_t enum (EMPTY/ONE/TWO) and the constant RD_CNT_W=16.
REQ-029 The 2-entry storage and head/tail pointers SHALL be a sub-module fifo_rd_skid (DSIZE parameter, push/pop/count ports); the FSM and rinc logic stay in fifo_rd_stream.

Verification
REQ-030 Reset: rrst=1 for 3 cycles with rempty=0 -> rinc=0, m_valid=0, m_data=0 throughout.
REQ-031 Streaming: FIFO preloaded with 0x01..0x10, m_ready=1 -> 16 words out in order, one per cycle after a 1-cycle initial latency, rinc high for 16 consecutive cycles.
REQ-032 Backpressure: m_ready=0 with data available -> exactly 2 pops; m_valid=1 and m_data=first word held stable; rinc=0 thereafter; after m_ready=1, remaining words arrive in order with none lost.
REQ-033 Empty boundary: FIFO holds 1 word (0xA5) -> single rinc, m_valid=1 with 0xA5 for one accepted cycle, then m_valid=0 and rinc=0.
REQ-034 Flush: flush in state TWO holding 0x11 and 0x22 -> next cycle m_valid=0, no rinc in the flush cycle; the next FIFO word (0x33) is delivered afterwards.
REQ-035 Counter (FIFO_RD_CNT_EN): 65537 accepted words -> rd_cnt=1; mid-stream rrst -> rd_cnt=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side stream adapter: read FSM states and counter width.
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } rd_state_t;

  localparam int unsigned RD_CNT_W = 16;

  // The FSM state encoding doubles as the buffered-word count.
  function automatic logic [1:0] state_count(input rd_state_t s);
    return logic'(s[1]) ? 2'd2 : {1'b0, s[0]};
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry word store with head/tail pointers; head word is presented from a register.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [DSIZE-1:0] din,
  input  logic [1:0]       count,
  output logic [DSIZE-1:0] dout
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DSIZE-1:0] mem   [DEPTH];
  logic [DSIZE-1:0] mem_n [DEPTH];
  logic [PW-1:0]    wptr, wptr_n;
  logic [PW-1:0]    rptr, rptr_n;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok = push && (count < 2'(DEPTH));
    pop_ok  = pop && (count != 2'd0);
    mem_n   = mem;
    wptr_n  = wptr;
    rptr_n  = rptr;
    if (push_ok) begin
      mem_n[wptr] = din;
      wptr_n      = wptr + 1'b1;
    end
    if (pop_ok) begin
      rptr_n = rptr + 1'b1;
    end
  end

  // dout follows the next head so the output stays a plain register.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wptr <= '0;
      rptr <= '0;
      dout <= '0;
    end else begin
      mem  <= mem_n;
      wptr <= wptr_n;
      rptr <= rptr_n;
      dout <= mem_n[rptr_n];
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read side to valid/ready stream adapter with a 2-word output buffer.
// Optional accepted-word counter rd_cnt enabled by macro FIFO_RD_CNT_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned SKID  = 2
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [RD_CNT_W-1:0] rd_cnt
`endif
);

  rd_state_t state_q, state_n;
  logic      valid_q;
  logic      push, pop;

  always_comb begin
    rinc = !rempty && (state_q != TWO) && !flush && !rrst;
    push = rinc;
    pop  = valid_q && m_ready && !flush && !rrst;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      EMPTY: if (push) state_n = ONE;
      ONE: begin
        if (push && !pop)      state_n = TWO;
        else if (pop && !push) state_n = EMPTY;
      end
      TWO:     if (pop) state_n = ONE;
      default: state_n = EMPTY;
    endcase
    if (flush) state_n = EMPTY;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      valid_q <= (state_n != EMPTY);
    end
  end

  assign m_valid = valid_q;

  fifo_rd_skid #(
    .DSIZE (DSIZE),
    .DEPTH (SKID)
  ) u_skid (
    .clk   (rclk),
    .clear (rrst || flush),
    .push  (push),
    .pop   (pop),
    .din   (rdata),
    .count (state_count(state_q)),
    .dout  (m_data)
  );

`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge rclk) begin
    if (rrst || flush) begin
      rd_cnt <= '0;
    end else if (valid_q && m_ready) begin
      rd_cnt <= rd_cnt + {{(RD_CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO environment, queue-based buffer model, directed scenarios.
module tb_fifo_rd_stream;

  logic       rclk = 1'b0;
  logic       rrst, rempty, flush, m_ready;
  logic       rinc, m_valid;
  logic [7:0] rdata, m_data;
`ifdef FIFO_RD_CNT_EN
  logic [15:0] rd_cnt;
`endif

  always #5 rclk = ~rclk;

  fifo_rd_stream #(
    .DSIZE (8),
    .SKID  (2)
  ) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .flush   (flush),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef FIFO_RD_CNT_EN
    ,
    .rd_cnt  (rd_cnt)
`endif
  );

  logic [7:0]  fifo_q [$];
  logic [7:0]  mq [$];
  logic [7:0]  out_log [$];
  int          checks = 0;
  int          errors = 0;
  bit          zero_flag, force_ne;
  bit          rinc_s, acc_s;
  logic [7:0]  data_s;
  int          rinc_total, rinc_run, rinc_max, tick_n, first_rinc, first_valid;
  logic [15:0] cnt_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    if (force_ne) begin
      rempty = 1'b0;
      rdata  = 8'hEE;
    end else if (fifo_q.size() == 0) begin
      rempty = 1'b1;
      rdata  = 8'h00;
    end else begin
      rempty = 1'b0;
      rdata  = fifo_q[0];
    end
  endtask

  task automatic compare();
    bit exp_rinc;
    exp_rinc = !rempty && (mq.size() < 2) && !flush && !rrst;
    chk("rinc", {31'd0, rinc}, {31'd0, exp_rinc});
    chk("m_valid", {31'd0, m_valid}, {31'd0, mq.size() > 0});
    if (mq.size() > 0) chk("m_data", {24'd0, m_data}, {24'd0, mq[0]});
    else if (zero_flag) chk("m_data_rst", {24'd0, m_data}, 32'd0);
`ifdef FIFO_RD_CNT_EN
    chk("rd_cnt", {16'd0, rd_cnt}, {16'd0, cnt_m});
`endif
  endtask

  task automatic clear_stats();
    out_log.delete();
    rinc_total  = 0;
    rinc_run    = 0;
    rinc_max    = 0;
    first_rinc  = -1;
    first_valid = -1;
    tick_n      = 0;
  endtask

  task automatic tick();
    bit exp_push, exp_pop;
    @(negedge rclk);
    compare();
    rinc_s = rinc;
    acc_s  = m_valid && m_ready && !flush && !rrst;
    data_s = m_data;
    if (rinc_s) begin
      rinc_total++;
      rinc_run++;
      if (rinc_run > rinc_max) rinc_max = rinc_run;
      if (first_rinc < 0) first_rinc = tick_n;
    end else begin
      rinc_run = 0;
    end
    if (m_valid && first_valid < 0) first_valid = tick_n;
    @(posedge rclk);
    exp_push = !rempty && (mq.size() < 2) && !flush && !rrst;
    exp_pop  = (mq.size() > 0) && m_ready && !flush && !rrst;
    if (rrst || flush) begin
      mq.delete();
      cnt_m = '0;
    end else begin
      if (exp_pop) begin
        void'(mq.pop_front());
        cnt_m = cnt_m + 16'd1;
      end
      if (exp_push) mq.push_back(rdata);
    end
    if (rrst) zero_flag = 1'b1;
    else if (exp_push) zero_flag = 1'b0;
    if (acc_s) out_log.push_back(data_s);
    if (rinc_s && !force_ne && fifo_q.size() > 0) void'(fifo_q.pop_front());
    tick_n++;
    #1;
    refresh();
  endtask

  initial begin
    rrst      = 1'b1;
    flush     = 1'b0;
    m_ready   = 1'b0;
    force_ne  = 1'b1;
    zero_flag = 1'b1;
    cnt_m     = '0;
    refresh();
    @(posedge rclk);
    #1;

    // Reset held with data apparently available.
    clear_stats();
    repeat (3) tick();
    chk("rst_rinc_total", rinc_total, 0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    rrst     = 1'b0;
    force_ne = 1'b0;
    refresh();

    // Streaming 0x01..0x10 with m_ready high.
    clear_stats();
    for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
    refresh();
    m_ready = 1'b1;
    repeat (20) tick();
    chk("stream_count", out_log.size(), 16);
    for (int i = 0; i < 16; i++) chk("stream_word", {24'd0, out_log[i]}, i + 1);
    chk("stream_rinc_run", rinc_max, 16);
    chk("stream_latency", first_valid - first_rinc, 1);

    // Backpressure: exactly two pops, head held, then full drain.
    clear_stats();
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'h40 + 8'(i));
    refresh();
    m_ready = 1'b0;
    repeat (6) tick();
    chk("bp_pops", rinc_total, 2);
    chk("bp_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_hold", {24'd0, m_data}, 32'h40);
    chk("bp_rinc_off", {31'd0, rinc}, 32'd0);
    chk("bp_no_out", out_log.size(), 0);
    m_ready = 1'b1;
    repeat (8) tick();
    chk("bp_count", out_log.size(), 5);
    for (int i = 0; i < 5; i++) chk("bp_word", {24'd0, out_log[i]}, 32'h40 + i);

    // Single word 0xA5.
    clear_stats();
    fifo_q.push_back(8'hA5);
    refresh();
    repeat (4) tick();
    chk("one_rinc_total", rinc_total, 1);
    chk("one_count", out_log.size(), 1);
    chk("one_word", {24'd0, out_log[0]}, 32'hA5);
    chk("one_valid_end", {31'd0, m_valid}, 32'd0);
    chk("one_rinc_end", {31'd0, rinc}, 32'd0);

    // Flush while holding 0x11, 0x22; 0x33 follows.
    clear_stats();
    m_ready = 1'b0;
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    refresh();
    repeat (3) tick();
    chk("fl_two_valid", {31'd0, m_valid}, 32'd1);
    chk("fl_two_head", {24'd0, m_data}, 32'h11);
    fifo_q.push_back(8'h33);
    refresh();
    flush = 1'b1;
    clear_stats();
    tick();
    chk("fl_rinc", rinc_total, 0);
    flush = 1'b0;
    chk("fl_valid", {31'd0, m_valid}, 32'd0);
    m_ready = 1'b1;
    repeat (4) tick();
    chk("fl_count", out_log.size(), 1);
    chk("fl_word", {24'd0, out_log[0]}, 32'h33);

    // Reset in mid-stream drops the buffered word.
    clear_stats();
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h60 + 8'(i));
    refresh();
    repeat (3) tick();
    rrst = 1'b1;
    tick();
    tick();
    chk("mrst_rinc", {31'd0, rinc}, 32'd0);
    chk("mrst_valid", {31'd0, m_valid}, 32'd0);
    rrst = 1'b0;
    repeat (12) tick();
    chk("mrst_count", out_log.size(), 7);
    chk("mrst_skip", {24'd0, out_log[2]}, 32'h63);
    chk("mrst_last", {24'd0, out_log[6]}, 32'h67);

`ifdef FIFO_RD_CNT_EN
    // 65537 accepted words wrap the counter to 1; reset clears it.
    rrst = 1'b1;
    tick();
    rrst = 1'b0;
    clear_stats();
    begin
      int fed;
      fed = 0;
      for (int n = 0; n < 65545; n++) begin
        while (fed < 65537 && fifo_q.size() < 4) begin
          fifo_q.push_back(8'(fed));
          fed++;
        end
        refresh();
        tick();
      end
    end
    chk("cnt_total", out_log.size(), 65537);
    chk("cnt_wrap", {16'd0, rd_cnt}, 32'd1);
    rrst = 1'b1;
    tick();
    rrst = 1'b0;
    chk("cnt_rst", {16'd0, rd_cnt}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
